// File: rtl/serial_tx_160_163.sv
// Framed serial transmitter: start bit, LSB-first data, optional even parity, stop bit.
// Each serial bit is held on TX for BIT_CYCLES clocks; TX, BUSY and DONE are flop outputs.
module serial_tx_160_163 #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BIT_CYCLES = 4,
  parameter int unsigned PARITY_EN  = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              LOAD,
  output logic              READY,
  output logic              TX,
  output logic              BUSY,
  output logic              DONE
);

  // Counter widths stay at least one bit so BIT_CYCLES=1 / DATA_W=1 still elaborate.
  localparam int unsigned CntW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BIT_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(DATA_W - 1);
  localparam logic            HasParity = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic accept;
  logic bit_end;
  logic last_bit;

  assign accept   = LOAD && (state_q == StIdle);
  assign bit_end  = (cnt_q == CntMax);
  assign last_bit = (idx_q == IdxMax);

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) state_d = StStart;
      end
      StStart: begin
        if (bit_end) state_d = StData;
      end
      StData: begin
        if (bit_end && last_bit) state_d = HasParity ? StParity : StStop;
      end
      StParity: begin
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (state_q != StIdle) begin
      cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
    end

    case (state_q)
      StIdle: begin
        if (accept) begin
          shreg_d = DATA_IN;
          par_d   = ^DATA_IN;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      StStart: begin
        if (bit_end) begin
          tx_d  = shreg_q[0];
          idx_d = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          if (last_bit) begin
            tx_d = HasParity ? par_q : 1'b1;
          end else begin
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_d[0];
            idx_d   = idx_q + IdxW'(1);
          end
        end
      end
      StParity: begin
        if (bit_end) tx_d = 1'b1;
      end
      StStop: begin
        if (bit_end) begin
          tx_d   = 1'b1;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign READY = (state_q == StIdle);
  assign TX    = tx_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

  // BUSY and READY are complementary views of "a frame is in flight".
  a_busy_vs_ready: assert property (@(posedge CLK) disable iff (!RST) BUSY != READY);
  a_done_in_idle:  assert property (@(posedge CLK) disable iff (!RST) DONE |-> READY);
  a_idle_high:     assert property (@(posedge CLK) disable iff (!RST) !BUSY |-> TX);

endmodule

// File: tb/tb_serial_tx_160_163.sv
// Bench for serial_tx_160_163: three builds (8b/4cyc/parity, 8b/4cyc/no parity,
// 4b/1cyc/parity); a line monitor rebuilds each frame and checks it against queued expectations.
module tb_serial_tx_160_163;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d0, d1;
  logic [3:0] d2;
  logic [2:0] load_v;
  logic [2:0] ready_v, tx_v, busy_v, done_v;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  serial_tx_160_163 #(.DATA_W(8), .BIT_CYCLES(4), .PARITY_EN(1)) u_dut0 (
    .CLK(clk), .RST(rst_n), .DATA_IN(d0), .LOAD(load_v[0]),
    .READY(ready_v[0]), .TX(tx_v[0]), .BUSY(busy_v[0]), .DONE(done_v[0])
  );
  serial_tx_160_163 #(.DATA_W(8), .BIT_CYCLES(4), .PARITY_EN(0)) u_dut1 (
    .CLK(clk), .RST(rst_n), .DATA_IN(d1), .LOAD(load_v[1]),
    .READY(ready_v[1]), .TX(tx_v[1]), .BUSY(busy_v[1]), .DONE(done_v[1])
  );
  serial_tx_160_163 #(.DATA_W(4), .BIT_CYCLES(1), .PARITY_EN(1)) u_dut2 (
    .CLK(clk), .RST(rst_n), .DATA_IN(d2), .LOAD(load_v[2]),
    .READY(ready_v[2]), .TX(tx_v[2]), .BUSY(busy_v[2]), .DONE(done_v[2])
  );

  typedef struct packed {
    logic [15:0] data;
    logic        par;
    logic [7:0]  len;
  } exp_t;

  typedef struct packed {
    logic [1:0]  inst;
    logic [15:0] data;
    logic        par;
    logic [7:0]  len;
  } vec_t;

  exp_t q0[$], q1[$], q2[$];

  function automatic int dw_of(int i);
    return (i == 2) ? 4 : 8;
  endfunction
  function automatic int bc_of(int i);
    return (i == 2) ? 1 : 4;
  endfunction
  function automatic int p_of(int i);
    return (i == 1) ? 0 : 1;
  endfunction

  function automatic void qpush(int i, exp_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction
  function automatic int qsize(int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction
  function automatic exp_t qpop(int i);
    case (i)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Expected TX waveform, one bit per clock, bit k = line value k cycles after TX falls.
  function automatic logic [63:0] model(logic [15:0] d, int dw, int bc, int p);
    logic [63:0] v;
    logic        b;
    logic        par;
    int          k;
    v   = '0;
    k   = 0;
    par = 1'b0;
    for (int j = 0; j < dw; j++) par = par ^ d[j];
    for (int s = 0; s < dw + 2 + p; s++) begin
      if (s == 0) b = 1'b0;
      else if (s <= dw) b = d[s-1];
      else if (p != 0 && s == dw + 1) b = par;
      else b = 1'b1;
      for (int c = 0; c < bc; c++) begin
        v[k] = b;
        k++;
      end
    end
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask

  task automatic bad(string name);
    n_chk++;
    $display("FAIL %s: condition not met at %0t", name, $time);
  endtask

  // Line monitor state, per instance
  logic        in_frame [3];
  logic        chk_next [3];
  logic [63:0] log_v    [3];
  int          len_a    [3];
  int          busy_n   [3];

  task automatic end_frame(int i);
    exp_t        e;
    logic [63:0] mv;
    int          dw, bc, p;
    dw = dw_of(i);
    bc = bc_of(i);
    p  = p_of(i);
    if (qsize(i) == 0) begin
      bad($sformatf("unexpected_frame%0d", i));
      return;
    end
    e  = qpop(i);
    mv = model(e.data, dw, bc, p);
    chk($sformatf("frame_len%0d", i), 64'(len_a[i]), 64'(e.len));
    chk($sformatf("frame_wave%0d", i), log_v[i], mv);
    if (p != 0) chk($sformatf("parity_bit%0d", i), 64'(log_v[i][(1+dw)*bc]), 64'(e.par));
    chk($sformatf("busy_span%0d", i), 64'(busy_n[i]), 64'(e.len));
    chk($sformatf("busy_at_done%0d", i), 64'(busy_v[i]), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      in_frame[i] = 1'b0;
      chk_next[i] = 1'b0;
      log_v[i]    = '0;
      len_a[i]    = 0;
      busy_n[i]   = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) begin
          in_frame[i] = 1'b0;
          chk_next[i] = 1'b0;
        end else begin
          if (chk_next[i]) begin
            chk($sformatf("done_pulse%0d", i), 64'(done_v[i]), 64'(0));
            chk_next[i] = 1'b0;
          end
          if (in_frame[i]) begin
            if (done_v[i]) begin
              end_frame(i);
              in_frame[i] = 1'b0;
              chk_next[i] = 1'b1;
            end else if (len_a[i] >= 63) begin
              bad($sformatf("frame_overrun%0d", i));
              in_frame[i] = 1'b0;
            end else begin
              log_v[i][len_a[i]] = tx_v[i];
              len_a[i]++;
              if (busy_v[i]) busy_n[i]++;
            end
          end else if (!tx_v[i]) begin
            in_frame[i] = 1'b1;
            log_v[i]    = '0;
            len_a[i]    = 1;
            busy_n[i]   = busy_v[i] ? 1 : 0;
          end
        end
      end
    end
  end

  task automatic set_data(int i, logic [15:0] d);
    case (i)
      0:       d0 = d[7:0];
      1:       d1 = d[7:0];
      default: d2 = d[3:0];
    endcase
  endtask

  task automatic send(int i, logic [15:0] d, bit push, logic par, logic [7:0] len);
    int t;
    exp_t e;
    if (push) begin
      e.data = d;
      e.par  = par;
      e.len  = len;
      qpush(i, e);
    end
    @(negedge clk);
    set_data(i, d);
    load_v[i] = 1'b1;
    t = 0;
    while (!ready_v[i] && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    load_v[i] = 1'b0;
    chk($sformatf("accept%0d", i), 64'(busy_v[i]), 64'(1));
  endtask

  task automatic wait_drain(int i, int budget);
    int t;
    t = 0;
    while (qsize(i) > 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("drain%0d", i), 64'(qsize(i)), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  vec_t tbl[9];

  initial begin
    int t;
    tbl[0] = '{inst: 2'd0, data: 16'h00A5, par: 1'b0, len: 8'd44};
    tbl[1] = '{inst: 2'd0, data: 16'h0001, par: 1'b1, len: 8'd44};
    tbl[2] = '{inst: 2'd0, data: 16'h0080, par: 1'b1, len: 8'd44};
    tbl[3] = '{inst: 2'd1, data: 16'h0001, par: 1'b0, len: 8'd40};
    tbl[4] = '{inst: 2'd1, data: 16'h00A5, par: 1'b0, len: 8'd40};
    tbl[5] = '{inst: 2'd2, data: 16'h000B, par: 1'b1, len: 8'd7};
    tbl[6] = '{inst: 2'd2, data: 16'h0000, par: 1'b0, len: 8'd7};
    tbl[7] = '{inst: 2'd2, data: 16'h0007, par: 1'b1, len: 8'd7};
    tbl[8] = '{inst: 2'd0, data: 16'h00FF, par: 1'b0, len: 8'd44};

    rst_n  = 1'b0;
    load_v = '0;
    d0 = '0;
    d1 = '0;
    d2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 64'(tx_v), 64'(3'b111));
    chk("rst_busy", 64'(busy_v), 64'(0));
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_tx", 64'(tx_v), 64'(3'b111));
    chk("idle_ready", 64'(ready_v), 64'(3'b111));
    chk("idle_busy", 64'(busy_v), 64'(0));
    chk("idle_done", 64'(done_v), 64'(0));

    for (int k = 0; k < 9; k++) begin
      send(int'(tbl[k].inst), tbl[k].data, 1'b1, tbl[k].par, tbl[k].len);
      wait_drain(int'(tbl[k].inst), 200);
    end

    // LOAD held high across two frames; mid-frame DATA_IN change must not leak in.
    qpush(0, '{data: 16'h00A5, par: 1'b0, len: 8'd44});
    qpush(0, '{data: 16'h003C, par: 1'b0, len: 8'd44});
    @(negedge clk);
    d0        = 8'hA5;
    load_v[0] = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!busy_v[0] && t < 20);
    d0 = 8'h3C;
    t = 0;
    while (!done_v[0] && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("gap_tx", 64'(tx_v[0]), 64'(1));
    chk("gap_ready", 64'(ready_v[0]), 64'(1));
    @(negedge clk);
    chk("b2b_tx", 64'(tx_v[0]), 64'(0));
    chk("b2b_busy", 64'(busy_v[0]), 64'(1));
    load_v[0] = 1'b0;
    wait_drain(0, 200);

    // Reset during data bit 3 of 8'hFF; the partial frame is not expected.
    send(0, 16'h00FF, 1'b0, 1'b0, 8'd0);
    repeat (17) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_tx", 64'(tx_v[0]), 64'(1));
    chk("rst_mid_busy", 64'(busy_v[0]), 64'(0));
    chk("rst_mid_ready", 64'(ready_v[0]), 64'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_tx", 64'(tx_v[0]), 64'(1));
    send(0, 16'h0000, 1'b1, 1'b0, 8'd44);
    wait_drain(0, 200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
